imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it as 32-bit words into instruction memory.  Rev 1.0
module imem_loader #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [8:0] C_DEPTH = 9'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_CSUM  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] word_q,  word_d;
   logic [7:0]  idx_q,   idx_d;
   logic [1:0]  cnt_q,   cnt_d;
   logic [7:0]  xor_q,   xor_d;
   logic [7:0]  len_q,   len_d;
   logic        err_q,   err_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         xor_q   <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         xor_q   <= xor_d;
         len_q   <= len_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      xor_d    = xor_q;
      len_d    = len_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start) begin
               state_d = S_LEN;
               err_d   = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               xor_d   = '0;
               word_d  = '0;
            end
         end
         S_LEN: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               if ((in_data == 8'd0) || ({1'b0, in_data} > C_DEPTH)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  len_d   = in_data;
                  xor_d   = in_data;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               word_d = {word_q[23:0], in_data};
               xor_d  = xor_q ^ in_data;
               cnt_d  = cnt_q + 2'd1;
               // Latch the write port here so it holds steadily outside WRITE.
               if (cnt_q == 2'd3) begin
                  addr_d  = {22'd0, idx_q, 2'b00};
                  wdata_d = {word_q[23:0], in_data};
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            busy   = 1'b1;
            mem_we = 1'b1;
            idx_d  = idx_q + 8'd1;
            if ((idx_q + 8'd1) == len_q) begin
               state_d = S_CSUM;
            end else begin
               state_d = S_DATA;
            end
         end
         S_CSUM: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               err_d   = (in_data != xor_q);
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: randomized scoreboard bench for imem_loader.  Rev 1.0
module tb_imem_loader;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_we, busy, done, err;
   logic [31:0] mem_addr, mem_wdata;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic e; logic [31:0] addr; logic [31:0] data; } res_t;

   wr_t  exp_wr[$];
   res_t exp_res[$];
   int   checks = 0;
   int   passes = 0;
   logic [31:0] last_addr = '0;
   logic [31:0] last_data = '0;
   logic done_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   // Reference model: interprets a whole stream at once.
   task automatic model_load(input bq_t s);
      int n;
      logic [7:0] x;
      res_t r;
      wr_t w;
      n = int'(s[0]);
      if (n == 0 || n > DEPTH) begin
         r.e = 1'b1;
      end else begin
         x = 8'h00;
         for (int i = 0; i <= 4 * n; i++) x = x ^ s[i];
         for (int k = 0; k < n; k++) begin
            w.addr = 32'(k * 4);
            w.data = {s[1 + 4*k], s[2 + 4*k], s[3 + 4*k], s[4 + 4*k]};
            exp_wr.push_back(w);
            last_addr = w.addr;
            last_data = w.data;
         end
         r.e = (s[4*n + 1] != x);
      end
      r.addr = last_addr;
      r.data = last_data;
      exp_res.push_back(r);
   endtask

   always @(negedge clk) done_prev <= done;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we) begin
            wr_t e;
            check("in_ready_during_write", {31'd0, in_ready}, 32'd0);
            if (exp_wr.size() == 0) begin
               fail_now("unexpected_write");
            end else begin
               e = exp_wr.pop_front();
               check("write_addr", mem_addr, e.addr);
               check("write_data", mem_wdata, e.data);
            end
         end
         if (done && !done_prev) begin
            res_t r;
            if (exp_res.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               r = exp_res.pop_front();
               check("done_err", {31'd0, err}, {31'd0, r.e});
               check("done_busy", {31'd0, busy}, 32'd0);
               check("hold_addr", mem_addr, r.addr);
               check("hold_data", mem_wdata, r.data);
            end
         end
      end
   end

   // gap < 0 selects a random gap of 0..3 idle cycles after the byte.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
      int t;
      int g;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      start    = 1'b0;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) fail_now("in_ready_timeout");
      @(posedge clk);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         start    = pulse && (i == 0);
      end
   endtask

   task automatic run_load(input bq_t s, input int gap, input bit pulse);
      int t;
      model_load(s);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < s.size(); i++)
         send_byte(s[i], (i == s.size() - 1) ? 0 : gap, pulse);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      t = 0;
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t == 100) fail_now("done_timeout");
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
   endtask

   initial begin
      bq_t s;
      int  n;
      logic [7:0] x;

      // Reset held for two cycles with a competing start.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

      s = {8'h01, 8'h20, 8'h08, 8'h00, 8'h01, 8'h28};
      run_load(s, 0, 1'b0);
      s = {8'h02, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h02, 8'h00};
      run_load(s, 0, 1'b0);
      s = {8'h01, 8'h20, 8'h08, 8'h00, 8'h01, 8'h28};
      run_load(s, 3, 1'b0);
      s = {8'h00};
      run_load(s, 0, 1'b0);
      s = {8'h41};
      run_load(s, 0, 1'b0);

      // Reset in the middle of a word: nothing must be written.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h20, 0, 1'b0);
      send_byte(8'h08, 0, 1'b0);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset    = 1'b0;
      in_valid = 1'b0;
      last_addr = '0;
      last_data = '0;
      s = {8'h01, 8'h20, 8'h08, 8'h00, 8'h01, 8'h28};
      run_load(s, 0, 1'b0);

      // Randomized loads, including a full-depth one and ignored starts.
      for (int it = 0; it < 30; it++) begin
         s.delete();
         if (it == 5) n = DEPTH;
         else if ($urandom_range(0, 7) == 0)
            n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 255));
         else n = int'($urandom_range(1, 6));
         s.push_back(8'(n));
         if (n >= 1 && n <= DEPTH) begin
            x = 8'(n);
            for (int i = 0; i < 4 * n; i++) begin
               s.push_back(8'($urandom));
               x = x ^ s[s.size() - 1];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            s.push_back(x);
         end
         run_load(s, -1, ($urandom_range(0, 1) == 1));
      end

      repeat (5) @(negedge clk);
      check("pending_writes", 32'(exp_wr.size()), 32'd0);
      check("pending_results", 32'(exp_res.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
